// File: rtl/rs_flag_bank_pkg.sv
// ============================================================================
//  Module      : rs_flag_bank_pkg
//  Description : Shared constants for the set/reset flag bank and the UART
//                status-channel index map.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rs_flag_bank_pkg;

    // Priority selection when set and clear hit a channel in the same cycle
    localparam int PRIO_CLEAR = 0;
    localparam int PRIO_SET   = 1;

    // Which UART event drives which status channel
    typedef enum int unsigned {
        UART_CH_RX_READY    = 0,
        UART_CH_RX_FRAME    = 1,
        UART_CH_RX_PARITY   = 2,
        UART_CH_RX_OVERRUN  = 3,
        UART_CH_TX_DONE     = 4,
        UART_CH_TX_EMPTY    = 5,
        UART_CH_RX_BREAK    = 6,
        UART_CH_RX_IDLE_TO  = 7
    } uart_ch_e;

endpackage

`default_nettype wire

// File: rtl/rs_flag_bank_cell.sv
// ============================================================================
//  Module      : rs_flag_cell
//  Description : One status channel: flag, sticky overrun, set-edge history
//                and auto-clear timeout counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rs_flag_cell
    import rs_flag_bank_pkg::*;
#(
    parameter int PRIORITY = PRIO_CLEAR,
    parameter int EDGE_SET = 0,
    parameter int TW       = 8,
    parameter int TIMEOUT  = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic s,
    input  logic r,
    input  logic clr,
    output logic flag,
    output logic ovr
);

    localparam logic [TW-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);
    localparam logic          SET_WINS = (PRIORITY == PRIO_SET);

    logic          s_d;
    logic [TW-1:0] cnt;
    logic          s_evt;
    logic          to_evt;
    logic          c_evt;
    logic          flag_nxt;
    logic          ovr_set;
    logic          ovr_nxt;
    logic          set_applied;

    always_comb begin
        s_evt    = (EDGE_SET != 0) ? (s & ~s_d) : s;
        to_evt   = (TIMEOUT != 0) && flag && (cnt == TO_LAST);
        c_evt    = r | clr | to_evt;

        flag_nxt = flag;
        if (s_evt && c_evt) begin
            flag_nxt = SET_WINS;
        end else if (s_evt) begin
            flag_nxt = 1'b1;
        end else if (c_evt) begin
            flag_nxt = 1'b0;
        end
        set_applied = s_evt & flag_nxt;

        // Overrun follows the same priority rule against the masked clear only
        ovr_set = s_evt & flag;
        ovr_nxt = ovr;
        if (ovr_set && clr) begin
            ovr_nxt = SET_WINS;
        end else if (ovr_set) begin
            ovr_nxt = 1'b1;
        end else if (clr) begin
            ovr_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flag <= 1'b0;
            ovr  <= 1'b0;
            s_d  <= 1'b0;
            cnt  <= '0;
        end else begin
            flag <= flag_nxt;
            ovr  <= ovr_nxt;
            s_d  <= s;
            if (!flag_nxt || set_applied) begin
                cnt <= '0;
            end else if (flag && (TIMEOUT != 0)) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/rs_flag_bank.sv
// ============================================================================
//  Module      : rs_flag_bank
//  Description : Bank of independent set/reset status flags with overrun
//                detect, auto-clear timeout, masked clear and one irq line.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rs_flag_bank
    import rs_flag_bank_pkg::*;
#(
    parameter int CH       = 8,
    parameter int PRIORITY = PRIO_CLEAR,
    parameter int EDGE_SET = 0,
    parameter int TW       = 8,
    parameter int TIMEOUT  = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CH-1:0] R,
    input  logic [CH-1:0] S,
    input  logic          clr_req,
    input  logic [CH-1:0] clr_mask,
    input  logic [CH-1:0] irq_en,
    output logic [CH-1:0] Out,
    output logic [CH-1:0] ovr,
    output logic          irq
);

    logic [CH-1:0] clr_vec;

    assign clr_vec = {CH{clr_req}} & clr_mask;

    generate
        for (genvar i = 0; i < CH; i++) begin : g_ch
            rs_flag_cell #(
                .PRIORITY (PRIORITY),
                .EDGE_SET (EDGE_SET),
                .TW       (TW),
                .TIMEOUT  (TIMEOUT)
            ) u_cell (
                .clk   (clk),
                .reset (reset),
                .s     (S[i]),
                .r     (R[i]),
                .clr   (clr_vec[i]),
                .flag  (Out[i]),
                .ovr   (ovr[i])
            );
        end
    endgenerate

    assign irq = |(Out & irq_en);

endmodule

`default_nettype wire

// File: tb/tb_rs_flag_bank.sv
// ============================================================================
//  Module      : tb_rs_flag_bank
//  Description : Directed bench; four parameter variants share one stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rs_flag_bank;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] R, S, clr_mask, irq_en;
    logic       clr_req;

    logic [7:0] out_c, ovr_c, out_s, ovr_s, out_e, ovr_e, out_t, ovr_t;
    logic       irq_c, irq_s, irq_e, irq_t;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rs_flag_bank #(.CH(8), .PRIORITY(0), .EDGE_SET(0), .TW(8), .TIMEOUT(0)) dut_c (
        .clk(clk), .reset(reset), .R(R), .S(S), .clr_req(clr_req), .clr_mask(clr_mask),
        .irq_en(irq_en), .Out(out_c), .ovr(ovr_c), .irq(irq_c));

    rs_flag_bank #(.CH(8), .PRIORITY(1), .EDGE_SET(0), .TW(8), .TIMEOUT(0)) dut_s (
        .clk(clk), .reset(reset), .R(R), .S(S), .clr_req(clr_req), .clr_mask(clr_mask),
        .irq_en(irq_en), .Out(out_s), .ovr(ovr_s), .irq(irq_s));

    rs_flag_bank #(.CH(8), .PRIORITY(0), .EDGE_SET(1), .TW(8), .TIMEOUT(0)) dut_e (
        .clk(clk), .reset(reset), .R(R), .S(S), .clr_req(clr_req), .clr_mask(clr_mask),
        .irq_en(irq_en), .Out(out_e), .ovr(ovr_e), .irq(irq_e));

    rs_flag_bank #(.CH(8), .PRIORITY(0), .EDGE_SET(0), .TW(8), .TIMEOUT(5)) dut_t (
        .clk(clk), .reset(reset), .R(R), .S(S), .clr_req(clr_req), .clr_mask(clr_mask),
        .irq_en(irq_en), .Out(out_t), .ovr(ovr_t), .irq(irq_t));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_all();
        R = 8'hFF;
        step();
        R = 8'h00;
    endtask

    initial begin
        reset = 1'b1; R = '0; S = '0; clr_req = 1'b0; clr_mask = '0; irq_en = '0;
        step(2);
        reset = 1'b0;
        check("rst_out", out_c, 8'h00);
        check("rst_ovr", ovr_c, 8'h00);
        check("rst_irq", irq_c, 1'b0);

        // set/clear coincidence
        S = 8'h01; R = 8'h01;
        step();
        S = 8'h00; R = 8'h00;
        check("prio_clear_out0", out_c[0], 1'b0);
        check("prio_set_out0", out_s[0], 1'b1);
        clear_all();

        // irq gating
        irq_en = 8'h80;
        S = 8'h80;
        step();
        S = 8'h00;
        check("irq_ch7_out", out_c, 8'h80);
        check("irq_ch7", irq_c, 1'b1);
        clear_all();
        check("irq_after_clr", irq_c, 1'b0);
        S = 8'h01;
        step();
        S = 8'h00;
        check("irq_ch0_out", out_c, 8'h01);
        check("irq_ch0", irq_c, 1'b0);
        clear_all();
        irq_en = 8'h00;

        // masked software clear, overrun stickiness
        S = 8'hFF;
        step(2);
        S = 8'h00;
        check("ovr_all", ovr_c, 8'hFF);
        clr_req = 1'b1; clr_mask = 8'h0F;
        step();
        clr_req = 1'b0; clr_mask = 8'h00;
        check("mclr_out", out_c, 8'hF0);
        check("mclr_ovr", ovr_c, 8'hF0);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        check("mask0_noop", out_c, 8'hF0);
        R = 8'hF0;
        step();
        R = 8'h00;
        check("r_out", out_c, 8'h00);
        check("r_keeps_ovr", ovr_c, 8'hF0);

        // reset mid-operation beats S
        irq_en = 8'hFF;
        S = 8'h0F;
        step();
        check("pre_rst_irq", irq_c, 1'b1);
        reset = 1'b1; S = 8'hFF; R = 8'h00;
        step();
        reset = 1'b0; S = 8'h00;
        check("mid_rst_out", out_c, 8'h00);
        check("mid_rst_ovr", ovr_c, 8'h00);
        check("mid_rst_irq", irq_c, 1'b0);
        irq_en = 8'h00;

        // edge-triggered set with S[2] held high
        S = 8'h04;
        step();
        check("edge_set", out_e[2], 1'b1);
        step(3);
        R = 8'h04;
        step();
        R = 8'h00;
        check("edge_r_clr", out_e[2], 1'b0);
        step(5);
        check("edge_held_stays0", out_e[2], 1'b0);
        check("edge_no_ovr", ovr_e[2], 1'b0);
        check("level_reasserts", out_c[2], 1'b1);
        S = 8'h00;
        step();
        S = 8'h04;
        step();
        S = 8'h00;
        check("edge_reset_again", out_e[2], 1'b1);
        clear_all();

        // auto-clear timeout on channel 1
        S = 8'h02;
        step();
        S = 8'h00;
        check("to_c1", out_t[1], 1'b1);
        for (int c = 2; c <= 5; c++) begin
            step();
            check($sformatf("to_c%0d", c), out_t[1], 1'b1);
        end
        step();
        check("to_c6", out_t[1], 1'b0);
        check("to_no_ovr", ovr_t[1], 1'b0);

        // re-set at cycle 3 restarts timeout and flags overrun
        S = 8'h02;
        step();
        S = 8'h00;
        step(2);
        S = 8'h02;
        step();
        S = 8'h00;
        check("reto_ovr", ovr_t[1], 1'b1);
        check("reto_c4", out_t[1], 1'b1);
        step(4);
        check("reto_c8", out_t[1], 1'b1);
        step();
        check("reto_c9", out_t[1], 1'b0);
        check("reto_ovr_kept", ovr_t[1], 1'b1);
        check("level_no_to", out_c[1], 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
